mult_error_sweep: RTL and testbench

Exhaustive characterisation engine for the approximate 8x8 unsigned multipliers. It generates every operand pair (A, B), drives them into a combinational multiplier under test, and computes the exact product internally. It accumulates error statistics for the returned product: sum of absolute error, maximum error and error count. It sits directly upstream and downstream of the multiplier on the evaluation harness, feeding A/B and consuming P, and hands the per-design metrics to the NSGA-II fitness readout.

---
 rtl/mult_error_sweep_if.sv | 55 +++++
 rtl/mult_error_sweep.sv | 178 +++++++++++++++++
 tb/tb_mult_error_sweep.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_error_sweep_if.sv
// -----------------------------------------------------------------------------
// mult_error_sweep_if
// Bundles the sweep engine's control, operand, product and result signals.
//   start     : one-cycle sweep request          (harness -> engine)
//   pause     : hold the sweep while high         (harness -> engine)
//   p_in      : product from multiplier under test (harness -> engine)
//   a_out     : operand A to the multiplier       (engine -> harness)
//   b_out     : operand B to the multiplier       (engine -> harness)
//   busy      : sweep in progress                 (engine -> harness)
//   done      : results valid and stable          (engine -> harness)
//   sum_err   : sum of absolute errors            (engine -> harness)
//   max_err   : largest absolute error            (engine -> harness)
//   err_count : number of wrong products          (engine -> harness)
// Modports: master = harness / fitness readout side, slave = sweep engine.
// -----------------------------------------------------------------------------
interface mult_error_sweep_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 pause;
    logic [WIDTH-1:0]     a_out;
    logic [WIDTH-1:0]     b_out;
    logic [2*WIDTH-1:0]   p_in;
    logic                 busy;
    logic                 done;
    logic [4*WIDTH-1:0]   sum_err;
    logic [2*WIDTH-1:0]   max_err;
    logic [2*WIDTH:0]     err_count;

    modport master (
        output start,
        output pause,
        output p_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  sum_err,
        input  max_err,
        input  err_count
    );

    modport slave (
        input  start,
        input  pause,
        input  p_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output sum_err,
        output max_err,
        output err_count
    );
endinterface

// File: rtl/mult_error_sweep.sv
// -----------------------------------------------------------------------------
// mult_error_sweep
// Exhaustive error characterisation of an approximate WIDTH x WIDTH unsigned
// multiplier. A 2*WIDTH-bit counter walks every operand pair (B fastest), the
// exact product is formed locally and compared with the returned p_in.
// Stage 1 registers |exact - p_in| and a not-equal flag; stage 2 folds them
// into sum / max / count accumulators.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards any partial sweep
//   bus : mult_error_sweep_if.slave (start, pause, p_in in; operands,
//         busy, done and error metrics out, all registered)
// -----------------------------------------------------------------------------
module mult_error_sweep #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mult_error_sweep_if.slave  bus
);
    localparam int PW = 2 * WIDTH;      // product / counter width
    localparam int SW = 4 * WIDTH;      // sum accumulator width
    localparam int CW = 2 * WIDTH + 1;  // error counter width (holds 2^PW)

    localparam logic [PW-1:0] CNT_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] CNT_ONES = {PW{1'b1}};
    localparam logic [PW-1:0] CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   cnt_r;
    logic [PW-1:0]   cnt_next_s;
    logic            sample_s;
    logic            clear_s;
    logic [PW-1:0]   exact_s;
    logic [PW-1:0]   abs_err_s;
    logic            ne_s;

    logic            s1_valid_r;
    logic [PW-1:0]   s1_abs_r;
    logic            s1_ne_r;

    logic [SW-1:0]   sum_err_r;
    logic [PW-1:0]   max_err_r;
    logic [CW-1:0]   err_count_r;
    logic            busy_r;
    logic            done_r;

    // Absolute difference via a one-bit-wider subtraction; the borrow bit
    // selects which operand order yields the magnitude.
    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x,
                                               input logic [PW-1:0] y);
        logic [PW:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[PW]) begin
            abs_diff = y - x;
        end else begin
            abs_diff = d[PW-1:0];
        end
    endfunction

    // Exact reference product and error of the returned product for the
    // operand pair currently presented.
    always_comb begin
        exact_s   = {{WIDTH{1'b0}}, cnt_r[PW-1:WIDTH]} * {{WIDTH{1'b0}}, cnt_r[WIDTH-1:0]};
        abs_err_s = abs_diff(exact_s, bus.p_in);
        ne_s      = (bus.p_in != exact_s);
    end

    // Next-state, next-counter and sample/clear strobes.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        sample_s     = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = CNT_ZERO;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (!bus.pause) begin
                    sample_s = 1'b1;
                    // The last pair keeps the counter at all-ones so the
                    // operands park there through DRAIN and DONE.
                    if (cnt_r == CNT_ONES) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register with busy/done decoded from the next state so both
    // flags are registered and change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand counter and stage-1 error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            s1_valid_r <= 1'b0;
            s1_abs_r   <= {PW{1'b0}};
            s1_ne_r    <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            s1_valid_r <= sample_s;
            s1_abs_r   <= abs_err_s;
            s1_ne_r    <= ne_s;
        end
    end

    // Stage-2 accumulators; a start clears them, otherwise a valid stage-1
    // sample is folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_err_r   <= {SW{1'b0}};
            max_err_r   <= {PW{1'b0}};
            err_count_r <= {CW{1'b0}};
        end else if (clear_s) begin
            sum_err_r   <= {SW{1'b0}};
            max_err_r   <= {PW{1'b0}};
            err_count_r <= {CW{1'b0}};
        end else if (s1_valid_r) begin
            sum_err_r   <= sum_err_r + {{(SW-PW){1'b0}}, s1_abs_r};
            if (s1_abs_r > max_err_r) begin
                max_err_r <= s1_abs_r;
            end else begin
                max_err_r <= max_err_r;
            end
            err_count_r <= err_count_r + {{(CW-1){1'b0}}, s1_ne_r};
        end else begin
            sum_err_r   <= sum_err_r;
            max_err_r   <= max_err_r;
            err_count_r <= err_count_r;
        end
    end

    assign bus.a_out     = cnt_r[PW-1:WIDTH];
    assign bus.b_out     = cnt_r[WIDTH-1:0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum_err   = sum_err_r;
    assign bus.max_err   = max_err_r;
    assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_mult_error_sweep.sv
// -----------------------------------------------------------------------------
// tb_mult_error_sweep
// Drives the sweep engine with several multiplier models (exact, zero,
// LSB-cleared, random-fault table), random pause pulses, a mid-sweep reset,
// an ignored start and back-to-back runs. Expected metrics come from a plain
// arithmetic pass over all operand pairs; a scoreboard checks the order of
// sampled operand pairs. The DUT is instantiated at WIDTH=4 so each full
// sweep is short; every expectation is derived from W.
// -----------------------------------------------------------------------------
module tb_mult_error_sweep;
    localparam int W     = 4;
    localparam int PW    = 2 * W;
    localparam int TOTAL = 1 << PW;
    localparam int OMAX  = (1 << W) - 1;

    logic clk;
    logic rst;
    int   mode;
    logic [PW-1:0] err_tab [TOTAL];

    int   n_cmp = 0;
    int   n_err = 0;
    int   sb_idx;
    bit   sb_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult_error_sweep_if #(.WIDTH(W)) bus ();

    mult_error_sweep #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier-under-test models
    function automatic logic [PW-1:0] mul_model(input int m, input int a, input int b);
        int e;
        e = a * b;
        case (m)
            0:       return PW'(e);
            1:       return '0;
            2:       return PW'(e & ~1);
            default: return err_tab[a * (1 << W) + b];
        endcase
    endfunction

    assign bus.p_in = mul_model(mode, int'(bus.a_out), int'(bus.b_out));

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference metrics from the definition over every operand pair
    task automatic ref_model(input int m, output longint s, output longint mx, output longint cnt);
        s = 0; mx = 0; cnt = 0;
        for (int a = 0; a <= OMAX; a++) begin
            for (int b = 0; b <= OMAX; b++) begin
                longint ex, p, d;
                ex = a * b;
                p  = longint'(mul_model(m, a, b));
                d  = (ex > p) ? ex - p : p - ex;
                s += d;
                if (d > mx) mx = d;
                if (d != 0) cnt++;
            end
        end
    endtask

    // Scoreboard: each sampled cycle must present the next pair in order
    always @(negedge clk) begin
        if (sb_on && bus.busy && !bus.pause && sb_idx < TOTAL) begin
            check_val("order", longint'({bus.a_out, bus.b_out}), longint'(sb_idx));
            sb_idx++;
        end
    end

    task automatic check_results(input string tag, input int m);
        longint s, mx, cnt;
        ref_model(m, s, mx, cnt);
        check_val({tag, "_sum"},  longint'(bus.sum_err),   s);
        check_val({tag, "_max"},  longint'(bus.max_err),   mx);
        check_val({tag, "_cnt"},  longint'(bus.err_count), cnt);
        check_val({tag, "_done"}, longint'(bus.done),      1);
        check_val({tag, "_busy"}, longint'(bus.busy),      0);
        check_val({tag, "_a"},    longint'(bus.a_out),     OMAX);
        check_val({tag, "_b"},    longint'(bus.b_out),     OMAX);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_a"},    longint'(bus.a_out),     0);
        check_val({tag, "_b"},    longint'(bus.b_out),     0);
        check_val({tag, "_busy"}, longint'(bus.busy),      0);
        check_val({tag, "_done"}, longint'(bus.done),      0);
        check_val({tag, "_sum"},  longint'(bus.sum_err),   0);
        check_val({tag, "_max"},  longint'(bus.max_err),   0);
        check_val({tag, "_cnt"},  longint'(bus.err_count), 0);
    endtask

    // Starts a sweep (start high in cycle 0) and returns the cycle in which
    // done is first seen plus the number of pause cycles inserted in RUN.
    task automatic run_sweep(input int m, input int n_pause, input int extra_start_at,
                             output int done_cyc, output int paused);
        int cyc;
        mode = m; paused = 0; sb_idx = 0; sb_on = 1'b1; done_cyc = -1;
        bus.pause = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        check_val("clr_sum",  longint'(bus.sum_err),   0);
        check_val("clr_max",  longint'(bus.max_err),   0);
        check_val("clr_cnt",  longint'(bus.err_count), 0);
        check_val("clr_done", longint'(bus.done),      0);
        while (cyc < TOTAL + n_pause + 40) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            check_val("busy_run", longint'(bus.busy), 1);
            bus.pause = (paused < n_pause) && bus.busy && (sb_idx < TOTAL) &&
                        ($urandom_range(0, 2) == 0);
            if (bus.pause) paused++;
            bus.start = (cyc == extra_start_at);
            @(posedge clk); #1;
            cyc++;
        end
        bus.pause = 1'b0;
        bus.start = 1'b0;
        sb_on = 1'b0;
        check_val("sampled", longint'(sb_idx), TOTAL);
    endtask

    initial begin
        int dc, np;
        rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; mode = 0;
        sb_on = 1'b0; sb_idx = 0;
        for (int i = 0; i < TOTAL; i++) err_tab[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep(0, 0, -1, dc, np);
        check_val("exact_cyc", dc, TOTAL + 2);
        check_results("exact", 0);

        run_sweep(1, 0, -1, dc, np);
        check_val("zero_cyc", dc, TOTAL + 2);
        check_results("zero", 1);

        run_sweep(2, 0, -1, dc, np);
        check_val("lsb_cyc", dc, TOTAL + 2);
        check_results("lsb", 2);

        run_sweep(0, 40, -1, dc, np);
        check_val("pause_cyc", dc, TOTAL + 2 + np);
        check_results("pause", 0);

        for (int i = 0; i < TOTAL; i++) begin
            int ex;
            ex = (i >> W) * (i & OMAX);
            err_tab[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, TOTAL - 1)) : PW'(ex);
        end
        run_sweep(3, 30, -1, dc, np);
        check_val("rand_cyc", dc, TOTAL + 2 + np);
        check_results("rand", 3);

        // Outputs hold in DONE; pause and idle cycles have no effect
        for (int i = 0; i < 6; i++) begin
            bus.pause = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.pause = 1'b0;
        check_results("hold", 3);

        // Reset in the middle of a sweep discards everything
        mode = 1; sb_idx = 0; sb_on = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1; sb_on = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midrst");
        run_sweep(0, 0, 200, dc, np);
        check_val("restart_cyc", dc, TOTAL + 2);
        check_results("restart", 0);

        // Back-to-back: stale zero-product results cleared by the next start
        run_sweep(1, 0, -1, dc, np);
        check_results("b2b_first", 1);
        run_sweep(0, 0, -1, dc, np);
        check_val("b2b_cyc", dc, TOTAL + 2);
        check_results("b2b_second", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
